// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: the ALU decoder
// operation codes it consumes, the FSM state encoding and operation classifiers.
package mul_div_unit_pkg;

    localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic is_md_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
               (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
    endfunction

    function automatic logic is_signed_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
    endfunction

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/mul_div_unit_abs_sign.sv
// Conditional two's-complement negation of a 2*WIDTH word, either as two
// independent WIDTH lanes (operand abs, quotient/remainder signs) or as one wide value (product).
module md_abs_sign #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] value_i,
    input  logic               wide_i,
    input  logic               neg_hi_i,
    input  logic               neg_lo_i,
    output logic [2*WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    assign hi = value_i[2*WIDTH-1:WIDTH];
    assign lo = value_i[WIDTH-1:0];

    // NOTE: value_o gets a full default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        value_o = value_i;
        if (wide_i) begin
            if (neg_lo_i) begin
                value_o = -value_i;
            end
        end else begin
            if (neg_hi_i) begin
                value_o[2*WIDTH-1:WIDTH] = -hi;
            end
            if (neg_lo_i) begin
                value_o[WIDTH-1:0] = -lo;
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit for EX: shift-add multiply and restoring
// divide on magnitudes, sign fix-up afterwards, start/stall/valid handshake.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [7:0]         alucontrolE,
    input  logic               start_i,
    input  logic               cancel_i,
    input  logic [WIDTH-1:0]   srcaE,
    input  logic [WIDTH-1:0]   srcbE,
    output logic               stall_o,
    output logic               result_valid_o,
    output logic [2*WIDTH-1:0] hilo_o
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    md_state_e          state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [2*WIDTH-1:0] work_q,    work_d;
    logic [WIDTH-1:0]   opnd_q,    opnd_d;
    logic [WIDTH-1:0]   src_a_q,   src_a_d;
    logic               is_div_q,  is_div_d;
    logic               signed_q,  signed_d;
    logic               sign_a_q,  sign_a_d;
    logic               sign_b_q,  sign_b_d;
    logic [2*WIDTH-1:0] hilo_q,    hilo_d;

    logic               accept;
    logic               in_signed;
    logic               in_neg_a;
    logic               in_neg_b;
    logic [2*WIDTH-1:0] in_abs;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    logic [2*WIDTH-1:0] fix_val;
    logic [2*WIDTH-1:0] fix_res;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;

    assign accept    = start_i && is_md_op(alucontrolE) && !cancel_i;
    assign in_signed = is_signed_op(alucontrolE);
    assign in_neg_a  = in_signed && srcaE[WIDTH-1];
    assign in_neg_b  = in_signed && srcbE[WIDTH-1];

    // Entry: magnitudes of both operands; 0x80000000 comes out as unsigned 2^31.
    md_abs_sign #(.WIDTH(WIDTH)) u_entry_abs (
        .value_i  ({srcaE, srcbE}),
        .wide_i   (1'b0),
        .neg_hi_i (in_neg_a),
        .neg_lo_i (in_neg_b),
        .value_o  (in_abs)
    );

    assign abs_a = in_abs[2*WIDTH-1:WIDTH];
    assign abs_b = in_abs[WIDTH-1:0];

    // Exit: product negated as one word; quotient and remainder negated per lane.
    md_abs_sign #(.WIDTH(WIDTH)) u_exit_sign (
        .value_i  (work_q),
        .wide_i   (!is_div_q),
        .neg_hi_i (signed_q && is_div_q && sign_a_q),
        .neg_lo_i (signed_q && (sign_a_q ^ sign_b_q)),
        .value_o  (fix_val)
    );

    always_comb begin
        fix_res = fix_val;
        if (is_div_q && (opnd_q == '0)) begin
            fix_res = {src_a_q, {WIDTH{1'b1}}};
        end
    end

    // Multiply step: work = {hi, multiplier}; add multiplicand on the bit leaving at LSB.
    always_comb begin
        mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, (work_q[0] ? opnd_q : '0)};
        mul_next = {mul_sum, work_q[WIDTH-1:1]};
    end

    // Divide step: work = {rem, quot}; remainder stays below the divisor, so the
    // difference always fits in WIDTH bits when the trial subtraction succeeds.
    always_comb begin
        div_shift = work_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        if (div_shift >= {1'b0, opnd_q}) begin
            div_next = {div_diff, work_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        work_d         = work_q;
        opnd_d         = opnd_q;
        src_a_d        = src_a_q;
        is_div_d       = is_div_q;
        signed_d       = signed_q;
        sign_a_d       = sign_a_q;
        sign_b_d       = sign_b_q;
        hilo_d         = hilo_q;
        stall_o        = 1'b0;
        result_valid_o = 1'b0;
        hilo_o         = hilo_q;

        unique case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    stall_o  = 1'b1;
                    state_d  = MD_RUN;
                    cnt_d    = '0;
                    is_div_d = is_div_op(alucontrolE);
                    signed_d = in_signed;
                    sign_a_d = in_neg_a;
                    sign_b_d = in_neg_b;
                    src_a_d  = srcaE;
                    if (is_div_op(alucontrolE)) begin
                        work_d = {{WIDTH{1'b0}}, abs_a};
                        opnd_d = abs_b;
                    end else begin
                        work_d = {{WIDTH{1'b0}}, abs_b};
                        opnd_d = abs_a;
                    end
                end
            end
            MD_RUN: begin
                stall_o = 1'b1;
                work_d  = is_div_q ? div_next : mul_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                stall_o = 1'b1;
                work_d  = fix_res;
                state_d = MD_DONE;
            end
            MD_DONE: begin
                result_valid_o = 1'b1;
                hilo_o         = work_q;
                hilo_d         = work_q;
                state_d        = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase

        // Cancel aborts from any state and keeps the previous result visible.
        if (cancel_i) begin
            state_d        = MD_IDLE;
            stall_o        = 1'b0;
            result_valid_o = 1'b0;
            hilo_o         = hilo_q;
            hilo_d         = hilo_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            opnd_q   <= '0;
            src_a_q  <= '0;
            is_div_q <= 1'b0;
            signed_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hilo_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            src_a_q  <= src_a_d;
            is_div_q <= is_div_d;
            signed_q <= signed_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            hilo_q   <= hilo_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: expected {HI,LO} values are queued at
// issue and popped when result_valid_o pulses; latency and stall are checked per op.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk;
    logic        resetn;
    logic [7:0]  alucontrolE;
    logic        start_i;
    logic        cancel_i;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        stall_o;
    logic        result_valid_o;
    logic [63:0] hilo_o;

    int          checks;
    int          errors;
    logic [63:0] exp_q[$];
    logic [63:0] last_hilo;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .alucontrolE    (alucontrolE),
        .start_i        (start_i),
        .cancel_i       (cancel_i),
        .srcaE          (srcaE),
        .srcbE          (srcbE),
        .stall_o        (stall_o),
        .result_valid_o (result_valid_o),
        .hilo_o         (hilo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resetn && result_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'(result_valid_o), 64'd0);
            end else begin
                check("hilo", hilo_o, exp_q.pop_front());
            end
        end
    end

    // Issues one op and follows it to its result pulse, checking stall and latency.
    task automatic run_op(input string tag, input logic [7:0] code,
                          input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        int lat;
        int stall_gaps;
        @(negedge clk);
        alucontrolE = code;
        srcaE       = a;
        srcbE       = b;
        start_i     = 1'b1;
        exp_q.push_back(exp);
        #1 check({tag, "_stall_t"}, 64'(stall_o), 64'd1);
        lat        = 0;
        stall_gaps = 0;
        while (lat < 60) begin
            @(negedge clk);
            start_i = 1'b0;
            lat++;
            if (result_valid_o) break;
            if (!stall_o) stall_gaps++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd34);
        check({tag, "_stall_gaps"}, 64'(stall_gaps), 64'd0);
        check({tag, "_stall_done"}, 64'(stall_o), 64'd0);
        last_hilo = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int gaps;
        checks      = 0;
        errors      = 0;
        last_hilo   = '0;
        resetn      = 1'b0;
        start_i     = 1'b0;
        cancel_i    = 1'b0;
        alucontrolE = 8'h00;
        srcaE       = '0;
        srcbE       = '0;
        repeat (3) @(negedge clk);
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_valid", 64'(result_valid_o), 64'd0);
        check("rst_hilo", hilo_o, 64'd0);
        resetn = 1'b1;

        run_op("multu_max", EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg",  EXE_MULT_OP,  32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("mult_mix",  EXE_MULT_OP,  32'h0000_0007, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFDD);
        run_op("div_neg",   EXE_DIV_OP,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_big",  EXE_DIVU_OP,  32'hFFFF_FFF9, 32'h0000_0002, 64'h0000_0001_7FFF_FFFC);
        run_op("div_negb",  EXE_DIV_OP,   32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
        run_op("divu_zero", EXE_DIVU_OP,  32'h1234_5678, 32'h0000_0000, 64'h1234_5678_FFFF_FFFF);
        run_op("div_zero",  EXE_DIV_OP,   32'hFFFF_FFF0, 32'h0000_0000, 64'hFFFF_FFF0_FFFF_FFFF);
        run_op("div_ovf",   EXE_DIV_OP,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

        // Cancel at t+10 of a DIV, then MULTU at t+12.
        @(negedge clk);
        alucontrolE = EXE_DIV_OP;
        srcaE       = 32'd100;
        srcbE       = 32'd7;
        start_i     = 1'b1;
        gaps        = 0;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (!stall_o) gaps++;
        end
        check("cancel_pre_stall", 64'(gaps), 64'd0);
        @(negedge clk);
        cancel_i = 1'b1;
        #1 check("cancel_stall", 64'(stall_o), 64'd0);
        check("cancel_valid", 64'(result_valid_o), 64'd0);
        @(negedge clk);
        cancel_i = 1'b0;
        check("cancel_hilo", hilo_o, last_hilo);
        check("cancel_idle_stall", 64'(stall_o), 64'd0);
        run_op("multu_after_cancel", EXE_MULTU_OP, 32'd3, 32'd5, 64'd15);

        // Cancel during DONE: no pulse, hilo_o keeps the previous result.
        @(negedge clk);
        alucontrolE = EXE_MULTU_OP;
        srcaE       = 32'd9;
        srcbE       = 32'd9;
        start_i     = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        @(posedge clk);
        #1 cancel_i = 1'b1;
        #1 check("done_cancel_valid", 64'(result_valid_o), 64'd0);
        check("done_cancel_hilo", hilo_o, last_hilo);
        @(posedge clk);
        #1 cancel_i = 1'b0;
        @(negedge clk);
        check("done_cancel_hilo_after", hilo_o, last_hilo);

        // Reset at t+20 of a MULT.
        @(negedge clk);
        alucontrolE = EXE_MULT_OP;
        srcaE       = 32'd11;
        srcbE       = 32'd13;
        start_i     = 1'b1;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_stall", 64'(stall_o), 64'd0);
        check("midrst_valid", 64'(result_valid_o), 64'd0);
        check("midrst_hilo", hilo_o, 64'd0);
        resetn    = 1'b1;
        last_hilo = '0;
        repeat (40) @(negedge clk);
        check("midrst_hilo_hold", hilo_o, 64'd0);

        // Non-MD op with start_i is ignored.
        @(negedge clk);
        alucontrolE = EXE_ADD_OP;
        srcaE       = 32'd1;
        srcbE       = 32'd2;
        start_i     = 1'b1;
        #1 check("add_stall", 64'(stall_o), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid_o) pulses++;
            if (stall_o) pulses++;
        end
        start_i = 1'b0;
        check("add_no_activity", 64'(pulses), 64'd0);

        run_op("mult_after_rst", EXE_MULT_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
